ram_block_copier: RTL and testbench

//   Requester-side engine for the word-addressed RAM port (in/load/address/out, combinational

---
 rtl/ram_block_copier_if.sv | 38 +++
 rtl/ram_block_copier.sv | 107 ++++++++++
 tb/tb_ram_block_copier.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_block_copier_if.sv
// Controller handshake plus word-addressed RAM port of the block copier.
// checksum_o exists only when RAM_COPY_CHECKSUM_EN is defined.
interface ram_block_copier_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              start_i;
  logic [ADDR_W-1:0] src_i;
  logic [ADDR_W-1:0] dst_i;
  logic [ADDR_W:0]   len_i;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic              ram_load_o;
  logic [DATA_W-1:0] ram_rdata_i;
`ifdef RAM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_o;

  modport master (
    input  start_i, src_i, dst_i, len_i, ram_rdata_i,
    output busy_o, done_o, ram_addr_o, ram_wdata_o, ram_load_o, checksum_o
  );
  modport slave (
    output start_i, src_i, dst_i, len_i, ram_rdata_i,
    input  busy_o, done_o, ram_addr_o, ram_wdata_o, ram_load_o, checksum_o
  );
`else
  modport master (
    input  start_i, src_i, dst_i, len_i, ram_rdata_i,
    output busy_o, done_o, ram_addr_o, ram_wdata_o, ram_load_o
  );
  modport slave (
    output start_i, src_i, dst_i, len_i, ram_rdata_i,
    input  busy_o, done_o, ram_addr_o, ram_wdata_o, ram_load_o
  );
`endif
endinterface

// File: rtl/ram_block_copier.sv
// Copies a block of RAM words src..src+len-1 to dst.., one read then one write cycle per word.
// Optional running checksum of written words behind RAM_COPY_CHECKSUM_EN.
//
//   state | meaning
//   IDLE  | waiting for start_i; all RAM outputs parked at zero
//   RD    | RAM addressed at current source word; read data captured at cycle end
//   WR    | captured word written to current destination; pointers advance
//   DONE  | one-cycle completion pulse; start_i ignored
module ram_block_copier #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input logic              clk_i,
  input logic              rst_n_i,
  ram_block_copier_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W:0]   remain;
  logic [DATA_W-1:0] data_q;
  logic              accept;
  logic              last_word;

  assign accept    = (state == IDLE) && bus.start_i;
  assign last_word = (remain == (ADDR_W+1)'(1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start_i) state_nxt = (bus.len_i == '0) ? DONE : RD;
      RD:   state_nxt = WR;
      WR:   state_nxt = last_word ? DONE : RD;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers wrap naturally at ADDR_W bits; remain is a down-counter to the last word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      remain  <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          src_ptr <= bus.src_i;
          dst_ptr <= bus.dst_i;
          remain  <= bus.len_i;
        end
        RD: data_q <= bus.ram_rdata_i;
        WR: begin
          src_ptr <= src_ptr + 1'b1;
          dst_ptr <= dst_ptr + 1'b1;
          remain  <= remain - (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy_o      = 1'b0;
    bus.done_o      = 1'b0;
    bus.ram_addr_o  = '0;
    bus.ram_wdata_o = '0;
    bus.ram_load_o  = 1'b0;
    case (state)
      RD: begin
        bus.busy_o     = 1'b1;
        bus.ram_addr_o = src_ptr;
      end
      WR: begin
        bus.busy_o      = 1'b1;
        bus.ram_addr_o  = dst_ptr;
        bus.ram_wdata_o = data_q;
        bus.ram_load_o  = 1'b1;
      end
      DONE: bus.done_o = 1'b1;
      default: ;
    endcase
  end

`ifdef RAM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)          checksum_q <= '0;
    else if (accept)       checksum_q <= '0;
    else if (state == WR)  checksum_q <= checksum_q + data_q;
  end

  assign bus.checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_ram_block_copier.sv
// Bench for ram_block_copier: RAM model, queue-based expected-output model, directed and random copies.
// Checksum checks are compiled in when RAM_COPY_CHECKSUM_EN is defined.
module tb_ram_block_copier;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int WORDS  = 64;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              load;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src = '0;
  logic [ADDR_W-1:0] dst = '0;
  logic [ADDR_W:0]   len = '0;
  logic [DATA_W-1:0] ram [WORDS];
  logic [DATA_W-1:0] model_mem [WORDS];
  exp_t              q[$];
  logic              pend_valid = 1'b0;
  logic [ADDR_W-1:0] pend_addr = '0;
  logic [DATA_W-1:0] pend_data = '0;
  logic [DATA_W-1:0] cks = '0;
  int                vectors = 0;
  int                miscompares = 0;

  ram_block_copier_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_if ();

  ram_block_copier #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (ram_if.master)
  );

  assign ram_if.start_i     = start;
  assign ram_if.src_i       = src;
  assign ram_if.dst_i       = dst;
  assign ram_if.len_i       = len;
  assign ram_if.ram_rdata_i = ram[ram_if.ram_addr_o];

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM array: write on rising edge when load is high
  initial forever begin
    @(posedge clk);
    if (ram_if.ram_load_o === 1'b1) ram[ram_if.ram_addr_o] = ram_if.ram_wdata_o;
  end

  // Expected per-cycle outputs for one copy, word-by-word ascending so overlap is modelled.
  task automatic model_accept(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                              input logic [ADDR_W:0] l);
    logic [DATA_W-1:0] scratch [WORDS];
    logic [ADDR_W-1:0] ra, wa;
    logic [DATA_W-1:0] v;
    scratch = model_mem;
    cks = '0;
    for (int k = 0; k < int'(l); k++) begin
      ra = s + ADDR_W'(k);
      wa = d + ADDR_W'(k);
      v  = scratch[ra];
      q.push_back({1'b1, 1'b0, 1'b0, ra, {DATA_W{1'b0}}});
      q.push_back({1'b1, 1'b0, 1'b1, wa, v});
      scratch[wa] = v;
    end
    q.push_back({1'b0, 1'b1, 1'b0, {ADDR_W{1'b0}}, {DATA_W{1'b0}}});
    q.push_back('0);
  endtask

  initial forever begin
    @(posedge clk);
    if (rst_n) begin
      if (pend_valid) begin
        model_mem[pend_addr] = pend_data;
        cks = cks + pend_data;
        pend_valid = 1'b0;
      end else if (q.size() == 0 && start) begin
        model_accept(src, dst, len);
      end
    end
  end

  initial forever begin
    exp_t e;
    exp_t act;
    @(negedge clk);
    e = (q.size() != 0) ? q.pop_front() : '0;
    if (e.load) begin
      pend_valid = 1'b1;
      pend_addr  = e.addr;
      pend_data  = e.wdata;
    end
    act = {ram_if.busy_o, ram_if.done_o, ram_if.ram_load_o, ram_if.ram_addr_o, ram_if.ram_wdata_o};
    chk("outputs", 32'(act), 32'(e));
`ifdef RAM_COPY_CHECKSUM_EN
    chk("checksum", 32'(ram_if.checksum_o), 32'(cks));
`endif
  end

  task automatic set_word(input int a, input logic [DATA_W-1:0] v);
    ram[a] = v;
    model_mem[a] = v;
  endtask

  // Called at a falling edge; start is seen at the next rising edge (edge 0).
  task automatic run_copy(input int s, input int d, input int l, input int hold,
                          output int done_cyc, output int busy_n, output int load_n,
                          output int done_n);
    int last;
    last = 2*l + 2;
    if (hold > last) last = hold;
    src = ADDR_W'(s);
    dst = ADDR_W'(d);
    len = (ADDR_W+1)'(l);
    start = 1'b1;
    done_cyc = -1; busy_n = 0; load_n = 0; done_n = 0;
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c >= hold) start = 1'b0;
      if (ram_if.busy_o) busy_n++;
      if (ram_if.ram_load_o) load_n++;
      if (ram_if.done_o) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    start = 1'b0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic reset_now();
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    q.delete();
    pend_valid = 1'b0;
    cks = '0;
    #1;
    chk("reset_outputs", {7'd0, ram_if.busy_o, ram_if.done_o, ram_if.ram_load_o,
                          ram_if.ram_addr_o, ram_if.ram_wdata_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int dc, bn, ln, dn, r;
    logic [DATA_W-1:0] wrap_w [4];
    logic [DATA_W-1:0] v41;

    for (int i = 0; i < WORDS; i++) set_word(i, DATA_W'($urandom));
    #1 rst_n = 1'b0;
    #1;
    chk("reset_state", {7'd0, ram_if.busy_o, ram_if.done_o, ram_if.ram_load_o,
                        ram_if.ram_addr_o, ram_if.ram_wdata_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) set_word(i, DATA_W'(i + 1));
    run_copy(0, 32, 4, 1, dc, bn, ln, dn);
    chk("t1_done_cycle", dc, 9);
    chk("t1_busy_cycles", bn, 8);
    chk("t1_load_pulses", ln, 4);
    chk("t1_done_pulses", dn, 1);
    for (int i = 0; i < 4; i++) chk("t1_mem", 32'(ram[32 + i]), i + 1);

    run_copy(7, 9, 0, 1, dc, bn, ln, dn);
    chk("t2_done_cycle", dc, 1);
    chk("t2_busy_cycles", bn, 0);
    chk("t2_load_pulses", ln, 0);

    wrap_w = '{16'hA0A0, 16'hB0B1, 16'hC0C2, 16'hD0D3};
    set_word(62, wrap_w[0]);
    set_word(63, wrap_w[1]);
    set_word(0, wrap_w[2]);
    set_word(1, wrap_w[3]);
    run_copy(62, 10, 4, 1, dc, bn, ln, dn);
    chk("t3_done_cycle", dc, 9);
    for (int i = 0; i < 4; i++) chk("t3_wrap_mem", 32'(ram[10 + i]), 32'(wrap_w[i]));

    run_copy(5, 20, 2, 7, dc, bn, ln, dn);
    chk("t4_done_cycle", dc, 5);
    chk("t4_done_pulses", dn, 1);
    chk("t4_busy_cycles", bn, 5);
    wait_idle();

    set_word(20, 16'h2020);
    set_word(42, 16'h4242);
    set_word(43, 16'h4343);
    v41 = ram[41];
    src = 6'd20; dst = 6'd40; len = 7'd4; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("t5_load_in_wr1", 32'(ram_if.ram_load_o), 32'd1);
    reset_now();
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ram_if.done_o) dn++;
    end
    chk("t5_no_done", dn, 0);
    chk("t5_mem40", 32'(ram[40]), 32'h2020);
    chk("t5_mem41", 32'(ram[41]), 32'(v41));
    chk("t5_mem42", 32'(ram[42]), 32'h4242);
    chk("t5_mem43", 32'(ram[43]), 32'h4343);

`ifdef RAM_COPY_CHECKSUM_EN
    set_word(50, 16'hFFFF);
    set_word(51, 16'h0002);
    set_word(52, 16'h0010);
    run_copy(50, 0, 3, 1, dc, bn, ln, dn);
    chk("t6_checksum", 32'(ram_if.checksum_o), 32'h0011);
`endif

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom % 3 == 0);
      src   = ADDR_W'($urandom);
      dst   = ADDR_W'($urandom);
      r     = int'($urandom % 8);
      len   = (r == 0) ? '0 : (r == 1) ? 7'd64 : (ADDR_W+1)'($urandom_range(1, 10));
      if (ram_if.busy_o && ($urandom % 200 == 0)) reset_now();
    end
    wait_idle();
    @(negedge clk);

    for (int i = 0; i < WORDS; i++) chk("final_mem", 32'(ram[i]), 32'(model_mem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
